// File: rtl/spi_ram_pkg.sv
// Shared frame constants, command/state enums and header encoding for spi_ram_master.
package spi_ram_pkg;

  localparam int HDR_LEN   = 3;
  localparam int PAY_LEN   = 8;
  localparam int RX_LEN    = 8;
  localparam int FRAME_LEN = HDR_LEN + PAY_LEN;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_HDR,
    ST_PAY,
    ST_TURN,
    ST_RX,
    ST_DESEL,
    ST_GAP
  } state_e;

  // The top command bit is repeated as the leading header bit.
  function automatic logic [HDR_LEN-1:0] cmd_hdr(input cmd_e cmd);
    logic [1:0] c;
    c = cmd;
    return {c[1], c};
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Frame datapath: 11-bit MSB-first TX shifter, 8-bit RX shifter and the 4-bit bit counter.
// Single-cycle register updates under control of the master FSM; no handshake of its own.
module spi_frame_shifter
  import spi_ram_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_load,
  input  logic [FRAME_LEN-1:0] tx_word,
  input  logic                 tx_shift,
  input  logic                 rx_shift,
  input  logic                 miso,
  input  logic                 cnt_load,
  input  logic [3:0]           cnt_init,
  output logic                 tx_bit,
  output logic [RX_LEN-1:0]    rx_next,
  output logic [3:0]           cnt
);

  logic [FRAME_LEN-1:0] tx_sr;
  logic [RX_LEN-1:0]    rx_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sr <= '0;
      rx_sr <= '0;
      cnt   <= '0;
    end else begin
      if (tx_load)
        tx_sr <= tx_word;
      else if (tx_shift)
        tx_sr <= {tx_sr[FRAME_LEN-2:0], 1'b0};
      if (rx_shift)
        rx_sr <= rx_next;
      // Free-running down-counter; the FSM reloads it on every state entry that needs it.
      if (cnt_load)
        cnt <= cnt_init;
      else
        cnt <= cnt - 4'd1;
    end
  end

  assign tx_bit  = tx_sr[FRAME_LEN-1];
  assign rx_next = {rx_sr[RX_LEN-2:0], miso};

endmodule

// File: rtl/spi_ram_master.sv
// SPI RAM master: one host request becomes an address frame plus a data frame (write 30 / read 39
// cycles at IDLE_GAP=2); req_ready only in IDLE, no queueing. Optional SPI_MASTER_ADDR_CACHE_EN.
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int IDLE_GAP = 2
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       ss_n,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [3:0] GAP_INIT = 4'(IDLE_GAP - 1);
  localparam logic [3:0] HDR_INIT = 4'(HDR_LEN - 1);
  localparam logic [3:0] PAY_INIT = 4'(PAY_LEN - 1);
  localparam logic [3:0] RX_INIT  = 4'(RX_LEN - 1);

  state_e               state, state_nxt;
  logic                 phase;  // 0: address frame, 1: data frame
  logic                 we_q;
  logic [7:0]           addr_q, wdata_q;
  logic [3:0]           gap_cnt, bit_cnt;
  logic                 accept, addr_hit;
  logic                 tx_load, tx_shift, rx_shift, cnt_load, tx_bit;
  logic [3:0]           cnt_init;
  logic [RX_LEN-1:0]    rx_next;
  logic [PAY_LEN-1:0]   pay;
  logic [FRAME_LEN-1:0] tx_word;
  cmd_e                 cmd;

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_valid) state_nxt = ST_SEL;
      ST_SEL:   state_nxt = ST_HDR;
      ST_HDR:   if (bit_cnt == 4'd0) state_nxt = ST_PAY;
      ST_PAY:   if (bit_cnt == 4'd0) state_nxt = (phase && !we_q) ? ST_TURN : ST_DESEL;
      ST_TURN:  state_nxt = ST_RX;
      ST_RX:    if (bit_cnt == 4'd0) state_nxt = ST_DESEL;
      ST_DESEL: state_nxt = ST_GAP;
      ST_GAP:   if (gap_cnt == 4'd0) state_nxt = phase ? ST_IDLE : ST_SEL;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ss_n      = 1'b1;
    mosi      = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    tx_load   = 1'b0;
    tx_shift  = 1'b0;
    rx_shift  = 1'b0;
    cnt_load  = 1'b0;
    cnt_init  = HDR_INIT;
    case (state)
      ST_IDLE: req_ready = 1'b1;
      ST_SEL: begin
        ss_n     = 1'b0;
        tx_load  = 1'b1;
        cnt_load = 1'b1;
        cnt_init = HDR_INIT;
      end
      ST_HDR: begin
        ss_n     = 1'b0;
        mosi     = tx_bit;
        tx_shift = 1'b1;
        if (bit_cnt == 4'd0) begin
          cnt_load = 1'b1;
          cnt_init = PAY_INIT;
        end
      end
      ST_PAY: begin
        ss_n     = 1'b0;
        mosi     = tx_bit;
        tx_shift = 1'b1;
      end
      ST_TURN: begin
        ss_n     = 1'b0;
        cnt_load = 1'b1;
        cnt_init = RX_INIT;
      end
      ST_RX: begin
        ss_n     = 1'b0;
        rx_shift = 1'b1;
      end
      ST_DESEL: rsp_valid = phase && !we_q;
      default: ;
    endcase
    busy = ~req_ready;
  end

  always_comb begin
    cmd = cmd_e'({~we_q, phase});
    if (!phase)
      pay = addr_q;
    else if (we_q)
      pay = wdata_q;
    else
      pay = 8'h00;
    tx_word = {cmd_hdr(cmd), pay};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q      <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      phase     <= 1'b0;
      gap_cnt   <= 4'd0;
      rsp_rdata <= 8'h00;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        phase   <= addr_hit;
      end else if (state == ST_GAP && gap_cnt == 4'd0) begin
        phase <= 1'b1;
      end
      if (state == ST_DESEL)
        gap_cnt <= GAP_INIT;
      else
        gap_cnt <= gap_cnt - 4'd1;
      // Capture includes the bit being sampled on this final RX edge.
      if (state == ST_RX && bit_cnt == 4'd0)
        rsp_rdata <= rx_next;
    end
  end

`ifdef SPI_MASTER_ADDR_CACHE_EN
  logic       wr_cache_vld, rd_cache_vld;
  logic [7:0] wr_cache_addr, rd_cache_addr;

  // Updated at accept: the address frame always follows unless reset, which clears both entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cache_vld  <= 1'b0;
      rd_cache_vld  <= 1'b0;
      wr_cache_addr <= 8'h00;
      rd_cache_addr <= 8'h00;
    end else if (accept) begin
      if (req_we) begin
        wr_cache_vld  <= 1'b1;
        wr_cache_addr <= req_addr;
      end else begin
        rd_cache_vld  <= 1'b1;
        rd_cache_addr <= req_addr;
      end
    end
  end

  assign addr_hit = req_we ? (wr_cache_vld && wr_cache_addr == req_addr)
                           : (rd_cache_vld && rd_cache_addr == req_addr);
`else
  assign addr_hit = 1'b0;
`endif

  spi_frame_shifter u_shifter (
    .clk      (clk),
    .rst      (rst),
    .tx_load  (tx_load),
    .tx_word  (tx_word),
    .tx_shift (tx_shift),
    .rx_shift (rx_shift),
    .miso     (miso),
    .cnt_load (cnt_load),
    .cnt_init (cnt_init),
    .tx_bit   (tx_bit),
    .rx_next  (rx_next),
    .cnt      (bit_cnt)
  );

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: behavioural SPI slave + RAM, transaction-level reference model.
module tb_spi_ram_master;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy, ss_n, mosi;
  logic       miso = 1'b0;

  always #5 clk = ~clk;

  spi_ram_master #(.IDLE_GAP(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .miso      (miso)
  );

  typedef struct packed {
    logic [2:0] hdr;
    logic [7:0] pay;
  } frame_t;

  int n_checks = 0;
  int n_fail   = 0;

  frame_t     got_q[$];
  frame_t     exp_q[$];
  logic [7:0] smem[256];
  logic [7:0] ref_mem[256];
  logic [7:0] s_wr_addr = 8'h00;
  logic [7:0] s_rd_addr = 8'h00;
  logic       fb[32];
  int         bit_idx = 0;
  int         hi_run = 0;
  int         min_gap = 1000;
  bit         seen_frame = 1'b0;
  int         mosi_bad = 0;
  int         rdy_bad = 0;
  int         rsp_cnt = 0;
  int         rsp_run = 0;
  int         rsp_run_max = 0;
  logic [7:0] rsp_last = 8'h00;
  logic [7:0] m_last_rdata = 8'h00;
`ifdef SPI_MASTER_ADDR_CACHE_EN
  bit         m_wr_vld = 1'b0;
  bit         m_rd_vld = 1'b0;
  logic [7:0] m_wr_addr = 8'h00;
  logic [7:0] m_rd_addr = 8'h00;
`endif

  // Slave side: a frame is the run of ss_n-low cycles; complete frames update the slave RAM.
  task automatic slave_frame_end();
    logic [2:0] h;
    logic [7:0] p;
    frame_t     f;
    h = {fb[1], fb[2], fb[3]};
    p = {fb[4], fb[5], fb[6], fb[7], fb[8], fb[9], fb[10], fb[11]};
    if (fb[0] === 1'b0 && ((h === 3'b111 && bit_idx == 21) || (h !== 3'b111 && bit_idx == 12))) begin
      f.hdr = h;
      f.pay = p;
      got_q.push_back(f);
      case (h)
        3'b000:  s_wr_addr = p;
        3'b001:  smem[s_wr_addr] = p;
        3'b110:  s_rd_addr = p;
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (ss_n !== 1'b0) begin
      if (mosi !== 1'b0) mosi_bad++;
      if (bit_idx > 0) slave_frame_end();
      bit_idx = 0;
      hi_run++;
      miso = 1'($urandom_range(0, 1));
    end else begin
      if (hi_run > 0 && seen_frame && hi_run < min_gap) min_gap = hi_run;
      hi_run = 0;
      seen_frame = 1'b1;
      if (bit_idx < 32) fb[bit_idx] = mosi;
      // Frame cycles 13..20 are RX of a read-data frame: present RAM data MSB first.
      if (bit_idx >= 13 && bit_idx <= 20 && {fb[1], fb[2], fb[3]} === 3'b111)
        miso = smem[s_rd_addr][20 - bit_idx];
      else
        miso = 1'($urandom_range(0, 1));
      bit_idx++;
    end
    if (req_ready !== ~busy) rdy_bad++;
    if (rsp_valid === 1'b1) begin
      rsp_cnt++;
      rsp_last = rsp_rdata;
      rsp_run++;
      if (rsp_run > rsp_run_max) rsp_run_max = rsp_run;
    end else begin
      rsp_run = 0;
    end
  end

  // Reference model: frames each request must produce and its busy length.
  task automatic model_req(input bit we, input logic [7:0] a, input logic [7:0] d, output int cyc);
    bit     hit;
    frame_t f;
    hit = 1'b0;
`ifdef SPI_MASTER_ADDR_CACHE_EN
    hit = we ? (m_wr_vld && m_wr_addr == a) : (m_rd_vld && m_rd_addr == a);
    if (we) begin m_wr_vld = 1'b1; m_wr_addr = a; end
    else    begin m_rd_vld = 1'b1; m_rd_addr = a; end
`endif
    cyc = 0;
    if (!hit) begin
      f.hdr = we ? 3'b000 : 3'b110;
      f.pay = a;
      exp_q.push_back(f);
      cyc += 13 + GAP;
    end
    f.hdr = we ? 3'b001 : 3'b111;
    f.pay = we ? d : 8'h00;
    exp_q.push_back(f);
    cyc += 13 + GAP + (we ? 0 : 9);
    if (we) ref_mem[a] = d;
    else    m_last_rdata = ref_mem[a];
  endtask

  task automatic model_reset();
`ifdef SPI_MASTER_ADDR_CACHE_EN
    m_wr_vld = 1'b0;
    m_rd_vld = 1'b0;
`endif
    m_last_rdata = 8'h00;
  endtask

  function automatic int frames_diff();
    int d;
    d = (got_q.size() == exp_q.size()) ? 0 : 1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  task automatic wait_ready();
    int w;
    w = 0;
    while (req_ready !== 1'b1 && w < 200) begin @(posedge clk); #1; w++; end
  endtask

  // Drives one request; cyc = edges from the accept edge until req_ready is seen high again.
  task automatic issue(input bit we, input logic [7:0] a, input logic [7:0] d, output int cyc);
    wait_ready();
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom_range(0, 1)); req_addr = 8'($urandom); req_wdata = 8'($urandom);
    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    model_reset();
    #2;
    n_checks++; if (ss_n !== 1'b1)      begin n_fail++; $display("FAIL reset_ss_n: got %b want 1", ss_n); end
    n_checks++; if (mosi !== 1'b0)      begin n_fail++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 00", rsp_rdata); end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_write_read();
    int exp_cyc, cyc, r0;
    got_q.delete(); exp_q.delete(); r0 = rsp_cnt;
    model_req(1'b1, 8'h3C, 8'hA5, exp_cyc);
    issue(1'b1, 8'h3C, 8'hA5, cyc);
    n_checks++; if (cyc !== exp_cyc) begin n_fail++; $display("FAIL wr_latency: got %0d want %0d", cyc, exp_cyc); end
    n_checks++; if (frames_diff() !== 0) begin n_fail++; $display("FAIL wr_frames: got %0d frames, %0d differ", got_q.size(), frames_diff()); end
    n_checks++; if (smem[8'h3C] !== ref_mem[8'h3C]) begin n_fail++; $display("FAIL wr_mem: got %h want %h", smem[8'h3C], ref_mem[8'h3C]); end
    n_checks++; if (rsp_cnt !== r0) begin n_fail++; $display("FAIL wr_no_rsp: got %0d pulses want 0", rsp_cnt - r0); end

    got_q.delete(); exp_q.delete(); r0 = rsp_cnt;
    model_req(1'b0, 8'h3C, 8'h00, exp_cyc);
    issue(1'b0, 8'h3C, 8'h00, cyc);
    n_checks++; if (cyc !== exp_cyc) begin n_fail++; $display("FAIL rd_latency: got %0d want %0d", cyc, exp_cyc); end
    n_checks++; if (frames_diff() !== 0) begin n_fail++; $display("FAIL rd_frames: got %0d frames, %0d differ", got_q.size(), frames_diff()); end
    n_checks++; if (rsp_cnt !== r0 + 1) begin n_fail++; $display("FAIL rd_rsp_count: got %0d want 1", rsp_cnt - r0); end
    n_checks++; if (rsp_last !== m_last_rdata) begin n_fail++; $display("FAIL rd_rdata: got %h want %h", rsp_last, m_last_rdata); end
  endtask

  task automatic test_random();
    int         exp_cyc, cyc, r0;
    bit         we;
    logic [7:0] a, d;
    for (int i = 0; i < 16; i++) begin
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       a = 8'h10;
        1:       a = 8'h3C;
        2:       a = 8'h20;
        default: a = 8'($urandom_range(0, 63));
      endcase
      d = 8'($urandom);
      got_q.delete(); exp_q.delete(); r0 = rsp_cnt;
      model_req(we, a, d, exp_cyc);
      issue(we, a, d, cyc);
      n_checks++; if (cyc !== exp_cyc) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, cyc, exp_cyc); end
      n_checks++; if (frames_diff() !== 0) begin n_fail++; $display("FAIL rand_frames[%0d]: got %0d frames, %0d differ", i, got_q.size(), frames_diff()); end
      n_checks++; if (rsp_cnt - r0 !== (we ? 0 : 1)) begin n_fail++; $display("FAIL rand_rsp_count[%0d]: got %0d want %0d", i, rsp_cnt - r0, we ? 0 : 1); end
      n_checks++; if (rsp_rdata !== m_last_rdata) begin n_fail++; $display("FAIL rand_rdata_hold[%0d]: got %h want %h", i, rsp_rdata, m_last_rdata); end
    end
  endtask

  task automatic test_back_to_back();
    int         cyc_a, cyc_b, cyc, r0;
    logic [7:0] a, d;
    a = 8'($urandom_range(0, 63));
    d = 8'($urandom);
    got_q.delete(); exp_q.delete(); r0 = rsp_cnt;
    model_req(1'b1, a, d, cyc_a);
    model_req(1'b0, a, 8'h00, cyc_b);
    wait_ready();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    // A different request held while busy must be dropped, not queued.
    req_we = 1'b1; req_addr = a ^ 8'h80; req_wdata = ~d;
    cyc = 0;
    repeat (10) begin @(posedge clk); #1; cyc++; end
    req_we = 1'b0; req_addr = a; req_wdata = 8'h00;
    while (req_ready !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    n_checks++; if (cyc !== cyc_a) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want %0d", cyc, cyc_a); end
    @(posedge clk); #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept_first_ready: got ready %b want 0", req_ready); end
    req_valid = 1'b0;
    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    n_checks++; if (cyc !== cyc_b) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want %0d", cyc, cyc_b); end
    n_checks++; if (frames_diff() !== 0) begin n_fail++; $display("FAIL b2b_frames: got %0d frames, %0d differ", got_q.size(), frames_diff()); end
    n_checks++; if (rsp_cnt !== r0 + 1) begin n_fail++; $display("FAIL b2b_rsp_count: got %0d want 1", rsp_cnt - r0); end
    n_checks++; if (rsp_last !== m_last_rdata) begin n_fail++; $display("FAIL b2b_rdata: got %h want %h", rsp_last, m_last_rdata); end
  endtask

  task automatic test_reset_mid();
    int         exp_cyc, cyc, r0;
    logic [7:0] old_v, new_v;
    frame_t     f0;
    old_v = ref_mem[8'h77];
    new_v = ~old_v;
    got_q.delete(); exp_q.delete(); r0 = rsp_cnt;
    wait_ready();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h77; req_wdata = new_v;
    @(posedge clk); #1;
    req_valid = 1'b0;
    // 0x77 is never cached here, so 22 edges after accept lands inside the write-data payload.
    repeat (22) @(posedge clk);
    #1;
    n_checks++; if (ss_n !== 1'b0) begin n_fail++; $display("FAIL mid_in_frame: got ss_n %b want 0", ss_n); end
    rst = 1'b1;
    #1;
    n_checks++; if (ss_n !== 1'b1)      begin n_fail++; $display("FAIL mid_rst_ss_n: got %b want 1", ss_n); end
    n_checks++; if (mosi !== 1'b0)      begin n_fail++; $display("FAIL mid_rst_mosi: got %b want 0", mosi); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 1", req_ready); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    model_reset();
    f0.hdr = 3'b000; f0.pay = 8'h77;
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL mid_frame_count: got %0d want 1", got_q.size()); end
    n_checks++; if (got_q[0] !== f0) begin n_fail++; $display("FAIL mid_addr_frame: got %h want %h", got_q[0], f0); end
    n_checks++; if (rsp_cnt !== r0) begin n_fail++; $display("FAIL mid_no_rsp: got %0d pulses want 0", rsp_cnt - r0); end
    n_checks++; if (rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL mid_rdata_cleared: got %h want 00", rsp_rdata); end
    n_checks++; if (smem[8'h77] !== old_v) begin n_fail++; $display("FAIL mid_mem_kept: got %h want %h", smem[8'h77], old_v); end

    got_q.delete(); exp_q.delete(); r0 = rsp_cnt;
    model_req(1'b0, 8'h77, 8'h00, exp_cyc);
    issue(1'b0, 8'h77, 8'h00, cyc);
    n_checks++; if (cyc !== exp_cyc) begin n_fail++; $display("FAIL mid_read_latency: got %0d want %0d", cyc, exp_cyc); end
    n_checks++; if (frames_diff() !== 0) begin n_fail++; $display("FAIL mid_read_frames: got %0d frames, %0d differ", got_q.size(), frames_diff()); end
    n_checks++; if (rsp_last !== old_v || rsp_cnt !== r0 + 1) begin n_fail++; $display("FAIL mid_read_old: got %h (%0d pulses) want %h (1)", rsp_last, rsp_cnt - r0, old_v); end
  endtask

  task automatic test_addr_cache();
    int exp_cyc, cyc;
    for (int i = 0; i < 2; i++) begin
      got_q.delete(); exp_q.delete();
      model_req(1'b1, 8'h10, (i == 0) ? 8'h11 : 8'h22, exp_cyc);
      issue(1'b1, 8'h10, (i == 0) ? 8'h11 : 8'h22, cyc);
      n_checks++; if (cyc !== exp_cyc) begin n_fail++; $display("FAIL cache_latency[%0d]: got %0d want %0d", i, cyc, exp_cyc); end
      n_checks++; if (frames_diff() !== 0) begin n_fail++; $display("FAIL cache_frames[%0d]: got %0d frames, %0d differ", i, got_q.size(), frames_diff()); end
    end
    n_checks++; if (smem[8'h10] !== 8'h22) begin n_fail++; $display("FAIL cache_mem: got %h want 22", smem[8'h10]); end
  endtask

  task automatic test_final_state();
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (smem[i] !== ref_mem[i]) bad++;
    n_checks++; if (bad !== 0)         begin n_fail++; $display("FAIL ram_contents: got %0d differing bytes want 0", bad); end
    n_checks++; if (mosi_bad !== 0)    begin n_fail++; $display("FAIL mosi_idle_low: got %0d cycles with mosi=1 while ss_n=1", mosi_bad); end
    n_checks++; if (rdy_bad !== 0)     begin n_fail++; $display("FAIL busy_vs_ready: got %0d cycles with busy==ready", rdy_bad); end
    n_checks++; if (rsp_run_max !== 1) begin n_fail++; $display("FAIL rsp_pulse_width: got %0d want 1", rsp_run_max); end
    n_checks++; if (min_gap < GAP + 1) begin n_fail++; $display("FAIL min_ss_high: got %0d want >= %0d", min_gap, GAP + 1); end
  endtask

  initial begin
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      smem[i] = v;
      ref_mem[i] = v;
    end
    test_reset();
    test_write_read();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_addr_cache();
    test_final_state();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
